// File: rtl/multi_dim_array_deser_if.sv
// Element-in / frame-out handshake bundle for the array deserializer.
// master = element source + frame consumer, slave = deserializer.
interface multi_dim_array_deser_if #(
  parameter int ELEM_W = 1,
  parameter int DIM0   = 3,
  parameter int DIM1   = 3,
  parameter int DIM2   = 3
);
  localparam int N  = DIM2 * DIM1 * DIM0;
  localparam int CW = $clog2(N + 1);

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [N*ELEM_W-1:0] out_arr;
  logic [CW-1:0]     out_count;
  logic              out_short;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_arr, out_count, out_short
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_arr, out_count, out_short
  );
endinterface

// File: rtl/multi_dim_array_deser.sv
// Stream-to-array deserializer: packs scalar elements into a [DIM2][DIM1][DIM0]
// frame (i0 fastest) and holds it until the consumer takes it.
module multi_dim_array_deser #(
  parameter int ELEM_W = 1,
  parameter int DIM0   = 3,
  parameter int DIM1   = 3,
  parameter int DIM2   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multi_dim_array_deser_if.slave  bus
);
  localparam int N   = DIM2 * DIM1 * DIM0;
  localparam int CW  = $clog2(N + 1);
  localparam int I0W = (DIM0 > 1) ? $clog2(DIM0) : 1;
  localparam int I1W = (DIM1 > 1) ? $clog2(DIM1) : 1;
  localparam int I2W = (DIM2 > 1) ? $clog2(DIM2) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state, state_nxt;
  logic [I0W-1:0]    i0;
  logic [I1W-1:0]    i1;
  logic [I2W-1:0]    i2;
  logic [CW-1:0]     count;
  logic [CW-1:0]     wr_idx;
  logic              short_q;
  logic [ELEM_W-1:0] slots [N];
  logic              accept, last_slot, close, release_fr;

  assign accept     = bus.in_valid && (state == FILL);
  assign last_slot  = (count == CW'(N - 1));
  assign close      = accept && (last_slot || bus.in_last);
  assign release_fr = (state == HOLD) && bus.out_ready;
  assign wr_idx     = CW'((int'(i2) * DIM1 + int'(i1)) * DIM0 + int'(i0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close)         state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = FILL;
      default:                    state_nxt = FILL;
    endcase
  end

  // Both handshake outputs come straight from state: no out_ready -> in_ready path.
  always_comb begin
    bus.in_ready  = (state == FILL);
    bus.out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i0 <= '0; i1 <= '0; i2 <= '0;
      count   <= '0;
      short_q <= 1'b0;
    end else if (release_fr) begin
      i0 <= '0; i1 <= '0; i2 <= '0;
      count   <= '0;
      short_q <= 1'b0;
    end else if (accept) begin
      count <= count + 1'b1;
      if (close) short_q <= !last_slot;
      if (i0 == I0W'(DIM0 - 1)) begin
        i0 <= '0;
        if (i1 == I1W'(DIM1 - 1)) begin
          i1 <= '0;
          i2 <= (i2 == I2W'(DIM2 - 1)) ? '0 : i2 + 1'b1;
        end else begin
          i1 <= i1 + 1'b1;
        end
      end else begin
        i0 <= i0 + 1'b1;
      end
    end
  end

  // One register per array slot; release clears so unfilled slots of a short frame read 0.
  for (genvar s = 0; s < N; s++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                slots[s] <= '0;
      else if (release_fr)                       slots[s] <= '0;
      else if (accept && (wr_idx == CW'(s)))     slots[s] <= bus.in_data;
    end
    assign bus.out_arr[s*ELEM_W +: ELEM_W] = slots[s];
  end

  assign bus.out_count = count;
  assign bus.out_short = short_q;
endmodule

// File: tb/tb_multi_dim_array_deser.sv
// Randomized bench for multi_dim_array_deser: a 1-bit 3x3x3 instance and a
// 4-bit 2x3x4 instance, each checked against a flat element-list model.
module tb_multi_dim_array_deser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_dim_array_deser_if #(.ELEM_W(1), .DIM0(3), .DIM1(3), .DIM2(3)) ifa ();
  multi_dim_array_deser_if #(.ELEM_W(4), .DIM0(4), .DIM1(3), .DIM2(2)) ifb ();

  multi_dim_array_deser #(.ELEM_W(1), .DIM0(3), .DIM1(3), .DIM2(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  multi_dim_array_deser #(.ELEM_W(4), .DIM0(4), .DIM1(3), .DIM2(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  logic       vals_a [27];
  logic [3:0] vals_b [24];

  // Reference: element k of the received list sits at flat slot k, the rest are zero.
  function automatic logic [26:0] model_a(input int n);
    logic [26:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = vals_a[k];
    return r;
  endfunction

  function automatic logic [95:0] model_b(input int n);
    logic [95:0] r = '0;
    for (int k = 0; k < n; k++) r[k*4 +: 4] = vals_b[k];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_a(input logic d, input logic l);
    int t = 0;
    ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_last = l;
    while (ifa.in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL push_a_timeout in_ready=%b required=1", ifa.in_ready);
    end
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] d, input logic l);
    int t = 0;
    ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_last = l;
    while (ifb.in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL push_b_timeout in_ready=%b required=1", ifb.in_ready);
    end
    @(negedge clk);
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
  endtask

  task automatic send_a(input int n, input bit lastf);
    for (int k = 0; k < n; k++) push_a(vals_a[k], lastf && (k == n - 1));
  endtask

  task automatic collect_a(input string name, input int n);
    int t = 0;
    while (ifa.out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (ifa.out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_out_valid got=%b required=1", name, ifa.out_valid);
    end
    checks++;
    if (ifa.out_arr !== model_a(n)) begin
      errors++; $display("FAIL %s_out_arr got=%h required=%h", name, ifa.out_arr, model_a(n));
    end
    checks++;
    if (ifa.out_count !== 5'(n)) begin
      errors++; $display("FAIL %s_out_count got=%0d required=%0d", name, ifa.out_count, n);
    end
    checks++;
    if (ifa.out_short !== (n < 27)) begin
      errors++; $display("FAIL %s_out_short got=%b required=%b", name, ifa.out_short, n < 27);
    end
    checks++;
    if (ifa.in_ready !== 1'b0) begin
      errors++; $display("FAIL %s_in_ready_hold got=%b required=0", name, ifa.in_ready);
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.out_arr !== 27'h0) begin
      errors++;
      $display("FAIL %s_release valid=%b ready=%b arr=%h required valid=0 ready=1 arr=0",
               name, ifa.out_valid, ifa.in_ready, ifa.out_arr);
    end
  endtask

  task automatic collect_b(input string name, input int n);
    int t = 0;
    while (ifb.out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (ifb.out_valid !== 1'b1 || ifb.out_arr !== model_b(n) ||
        ifb.out_count !== 5'(n) || ifb.out_short !== (n < 24)) begin
      errors++;
      $display("FAIL %s_frame valid=%b arr=%h cnt=%0d short=%b required arr=%h cnt=%0d short=%b",
               name, ifb.out_valid, ifb.out_arr, ifb.out_count, ifb.out_short,
               model_b(n), n, n < 24);
    end
    ifb.out_ready = 1'b1;
    @(negedge clk);
    ifb.out_ready = 1'b0;
    checks++;
    if (ifb.out_valid !== 1'b0 || ifb.in_ready !== 1'b1 || ifb.out_arr !== 96'h0) begin
      errors++;
      $display("FAIL %s_release valid=%b ready=%b arr=%h required valid=0 ready=1 arr=0",
               name, ifb.out_valid, ifb.in_ready, ifb.out_arr);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.out_arr !== 27'h0 ||
        ifa.out_count !== 5'd0 || ifa.out_short !== 1'b0) begin
      errors++;
      $display("FAIL reset_a ready=%b valid=%b arr=%h cnt=%0d short=%b required 1 0 0 0 0",
               ifa.in_ready, ifa.out_valid, ifa.out_arr, ifa.out_count, ifa.out_short);
    end
    checks++;
    if (ifb.in_ready !== 1'b1 || ifb.out_valid !== 1'b0 || ifb.out_arr !== 96'h0 ||
        ifb.out_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_b ready=%b valid=%b arr=%h cnt=%0d required 1 0 0 0",
               ifb.in_ready, ifb.out_valid, ifb.out_arr, ifb.out_count);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_full_frame;
    for (int k = 0; k < 27; k++) vals_a[k] = 1'b1;
    send_a(27, 1'b1);
    checks++;
    if (ifa.out_arr !== 27'h7FFFFFF) begin
      errors++; $display("FAIL full_const got=%h required=7ffffff", ifa.out_arr);
    end
    collect_a("full", 27);
  endtask

  task automatic test_ordering;
    for (int k = 0; k < 27; k++) vals_a[k] = 1'(k % 2);
    send_a(27, 1'b0);
    checks++;
    if (ifa.out_arr !== 27'h2AAAAAA) begin
      errors++; $display("FAIL order_const got=%h required=2aaaaaa", ifa.out_arr);
    end
    // element [1][1][1] is flat index (1*3+1)*3+1 = 13
    checks++;
    if (ifa.out_arr[13] !== 1'b1) begin
      errors++; $display("FAIL order_elem111 got=%b required=1", ifa.out_arr[13]);
    end
    collect_a("order", 27);
  endtask

  task automatic test_short_frame;
    for (int k = 0; k < 27; k++) vals_a[k] = (k < 5) ? 1'b1 : 1'($urandom);
    send_a(5, 1'b1);
    checks++;
    if (ifa.out_arr !== 27'h000001F) begin
      errors++; $display("FAIL short_const got=%h required=000001f", ifa.out_arr);
    end
    collect_a("short", 5);
    for (int k = 0; k < 27; k++) vals_a[k] = 1'($urandom);
    send_a(27, 1'b0);
    collect_a("after_short", 27);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      int  n = $urandom_range(1, 27);
      bit  lf = (n < 27) ? 1'b1 : 1'($urandom);
      for (int k = 0; k < 27; k++) vals_a[k] = 1'($urandom);
      send_a(n, lf);
      collect_a("random", n);
    end
  endtask

  task automatic test_back_pressure;
    logic d0;
    for (int k = 0; k < 27; k++) vals_a[k] = 1'($urandom);
    send_a(27, 1'b0);
    d0 = 1'($urandom);
    ifa.in_valid = 1'b1; ifa.in_data = d0; ifa.in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1 ||
          ifa.out_arr !== model_a(27) || ifa.out_count !== 5'd27) begin
        errors++;
        $display("FAIL bp_hold ready=%b valid=%b arr=%h cnt=%0d required 0 1 %h 27",
                 ifa.in_ready, ifa.out_valid, ifa.out_arr, ifa.out_count, model_a(27));
      end
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    ifa.out_ready = 1'b0;
    checks++;
    if (ifa.in_ready !== 1'b1 || ifa.out_count !== 5'd0) begin
      errors++;
      $display("FAIL bp_release ready=%b cnt=%0d required ready=1 cnt=0", ifa.in_ready, ifa.out_count);
    end
    for (int k = 1; k < 27; k++) vals_a[k] = 1'($urandom);
    vals_a[0] = d0;
    send_a(27, 1'b0);
    collect_a("bp_next", 27);
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 27; k++) vals_a[k] = 1'($urandom);
    vals_a[0] = 1'b1;
    send_a(12, 1'b0);
    checks++;
    if (ifa.out_count !== 5'd12) begin
      errors++; $display("FAIL rst_precount got=%0d required=12", ifa.out_count);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_count !== 5'd0 || ifa.out_arr !== 27'h0 ||
        ifa.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async valid=%b cnt=%0d arr=%h ready=%b required 0 0 0 1",
               ifa.out_valid, ifa.out_count, ifa.out_arr, ifa.in_ready);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    for (int k = 0; k < 27; k++) vals_a[k] = 1'($urandom);
    send_a(27, 1'b1);
    collect_a("post_rst", 27);
  endtask

  task automatic test_wide;
    for (int k = 0; k < 24; k++) vals_b[k] = 4'(k % 16);
    for (int k = 0; k < 24; k++) push_b(vals_b[k], 1'b0);
    checks++;
    if (ifb.out_arr[23*4 +: 4] !== 4'd7 || ifb.out_arr[15*4 +: 4] !== 4'd15) begin
      errors++;
      $display("FAIL wide_nibbles n23=%0d n15=%0d required 7 15",
               ifb.out_arr[23*4 +: 4], ifb.out_arr[15*4 +: 4]);
    end
    collect_b("wide_seq", 24);
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 24);
      for (int k = 0; k < 24; k++) vals_b[k] = 4'($urandom);
      for (int k = 0; k < n; k++) push_b(vals_b[k], k == n - 1);
      collect_b("wide_rand", n);
    end
  endtask

  initial begin
    ifa.in_valid = 0; ifa.in_data = '0; ifa.in_last = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.in_last = 0; ifb.out_ready = 0;
    test_reset();
    test_full_frame();
    test_ordering();
    test_short_frame();
    test_random();
    test_back_pressure();
    test_async_reset();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_dim_array_deser.md
Name: multi_dim_array_deser

Overview:
- Stream-to-array deserializer, the receive-side counterpart of the array passthrough path.
- Accepts scalar elements one per handshake on a valid/ready stream and assembles them into a packed 3-D array.
- Presents the completed frame on a second valid/ready interface.
- Sits between a serial element source (e.g. a cocotb driver or upstream serializer) and logic consuming a packed [DIM2][DIM1][DIM0] array.

Parameters:
ELEM_W, 1, width of one array element in bits
DIM0, 3, innermost (fastest-varying) dimension size
DIM1, 3, middle dimension size
DIM2, 3, outermost dimension size

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  block can accept an element
in_data  in  ELEM_W  element value
in_last  in  1  marks final element of a frame (may come early)
out_valid  out  1  assembled frame available
out_ready  in  1  consumer accepts frame
out_arr  out  DIM2*DIM1*DIM0*ELEM_W  assembled array, packed layout
out_count  out  clog2(DIM2*DIM1*DIM0+1)  number of elements actually received in frame
out_short  out  1  frame ended by in_last before array full

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=FILL, in_ready=1, out_valid=0.
  - out_arr=0, out_count=0, out_short=0.
  - Index counters i0=i1=i2=0.
- Layout: element [i2][i1][i0] occupies bits ((i2*DIM1+i1)*DIM0+i0)*ELEM_W +: ELEM_W. This equals SV packed [DIM2-1:0][DIM1-1:0][DIM0-1:0][ELEM_W-1:0].
- Fill order: i0 increments first. On i0 wrap to 0, i1 increments. On i1 wrap, i2 increments. Element k lands at flat index k.
- FSM, two states:
  - FILL: in_ready=1, out_valid=0.
    - Each in_valid&in_ready cycle writes in_data into the current slot, increments the indices and increments the count.
    - Go to HOLD when the accepted element is the last slot (flat index N-1, N=DIM2*DIM1*DIM0), or when in_last=1.
  - HOLD: in_ready=0, out_valid=1. out_arr, out_count and out_short are stable.
    - On out_ready=1: go to FILL, clear out_arr to 0, clear indices and count.
- Latency: final element accepted on edge N → out_valid high in the cycle after that edge. Frame release on edge M → in_ready high in the cycle after edge M.
- No combinational path from out_ready to in_ready. Single buffer: no overlap between frames, one idle handshake cycle per frame.
- out_short:
  - Set to 1 if the frame closes via in_last with count < N.
  - in_last on the N-th element → out_short=0.
  - Unreceived slots read 0 because the buffer is cleared on release.
- No in_last at the N-th element: frame closes anyway, out_short=0. The next element starts a new frame (no overflow or wrap into the held frame).
- in_valid while in HOLD: ignored, not consumed (in_ready=0). Source must hold data per valid/ready rules.
- out_ready while out_valid=0: no effect.
- out_valid, once high, stays high until accepted; outputs must not change while out_valid=1 and out_ready=0.
- in_last with in_valid=0: ignored.
- rst_n low at any time, including mid-frame or in HOLD: immediately return to reset values. The partial frame is discarded.
- Counter widths are sized for N; no arithmetic overflow is reachable.

Test Plan:
- Full frame, defaults: stream 27 elements of 1, in_last on the 27th, out_ready=1 → one cycle with out_valid=1, out_arr=27'h7FFFFFF, out_count=27, out_short=0.
- Ordering: stream bit k = k%2, no in_last → out_arr=27'h2AAAAAA, out_count=27; with DIM0=3,DIM1=3,DIM2=3, element k=13 appears at [1][1][1].
- Short frame: 5 elements of 1, in_last on the 5th → out_arr=27'h000001F, out_count=5, out_short=1; the next frame starts from index 0 and unfilled bits are 0.
- Backpressure: hold out_ready=0 for 10 cycles after completion while in_valid=1 → in_ready=0 throughout, out_arr stable, no element consumed; on out_ready=1, in_ready rises the following cycle and the pending element becomes element 0 of the next frame.
- Async reset mid-frame: assert rst_n=0 between clock edges after 12 elements → out_valid, out_count and out_arr go to 0 without waiting for clk; after release, a fresh 27-element frame produces the correct array.
- ELEM_W=4, DIM=2x3x4: stream k=0..23 as in_data=k%16 → out_arr nibble k equals k%16, out_count=24.
